// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: receives a counted, checksummed stream of
// big-endian 32-bit words and writes them into instruction memory while holding the core in reset.
module instruction_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic        ByteValid,
   input  logic [7:0]  ByteData,
   output logic        ByteReady,
   output logic        MemWrite,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        CoreReset,
   output logic        Done,
   output logic        Error,
   output logic [7:0]  WordsLoaded
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      DATA  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  word_cnt_q, word_cnt_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  checksum_q, checksum_d;
   logic [31:0] shift_q, shift_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic [7:0]  words_loaded_q, words_loaded_d;
   logic        accept;
   logic [7:0]  word_next;

   assign ByteReady    = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
   assign accept       = ByteReady && ByteValid;
   assign word_next    = word_cnt_q + 8'd1;
   assign MemWrite     = mem_write_q;
   assign MemAddress   = mem_addr_q;
   assign MemWriteData = mem_data_q;
   assign WordsLoaded  = words_loaded_q;
   assign Done         = (state_q == DONE);
   assign Error        = (state_q == ERR);
   assign CoreReset    = (state_q != DONE);

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      word_cnt_d     = word_cnt_q;
      byte_idx_d     = byte_idx_q;
      checksum_d     = checksum_q;
      shift_d        = shift_q;
      mem_write_d    = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_data_d     = mem_data_q;
      words_loaded_d = words_loaded_q;

      // Address and word count advance at the end of each write pulse,
      // independent of where the FSM has moved in the meantime.
      if (mem_write_q) begin
         mem_addr_d     = mem_addr_q + 32'd4;
         words_loaded_d = words_loaded_q + 8'd1;
      end

      case (state_q)
         IDLE, DONE, ERR: begin
            if (Start) begin
               state_d        = COUNT;
               checksum_d     = 8'h00;
               byte_idx_d     = 2'd0;
               word_cnt_d     = 8'd0;
               words_loaded_d = 8'd0;
               mem_addr_d     = BASE_ADDR;
            end
         end
         COUNT: begin
            if (accept) begin
               count_d    = ByteData;
               checksum_d = ByteData;
               state_d    = (ByteData == 8'd0) ? CHECK : DATA;
            end
         end
         DATA: begin
            if (accept) begin
               checksum_d = checksum_q ^ ByteData;
               shift_d    = {shift_q[23:0], ByteData};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  mem_write_d = 1'b1;
                  mem_data_d  = {shift_q[23:0], ByteData};
                  word_cnt_d  = word_next;
                  if (word_next == count_q) begin
                     state_d = CHECK;
                  end
               end
            end
         end
         CHECK: begin
            if (accept) begin
               state_d = (ByteData == checksum_q) ? DONE : ERR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q        <= IDLE;
         count_q        <= 8'd0;
         word_cnt_q     <= 8'd0;
         byte_idx_q     <= 2'd0;
         checksum_q     <= 8'h00;
         shift_q        <= 32'h0;
         mem_write_q    <= 1'b0;
         mem_addr_q     <= BASE_ADDR;
         mem_data_q     <= 32'h0;
         words_loaded_q <= 8'd0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         word_cnt_q     <= word_cnt_d;
         byte_idx_q     <= byte_idx_d;
         checksum_q     <= checksum_d;
         shift_q        <= shift_d;
         mem_write_q    <= mem_write_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_q     <= mem_data_d;
         words_loaded_q <= words_loaded_d;
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: good/bad checksum, empty load,
// gapped stream, Start while busy, and reset mid-session.
module tb_instruction_loader;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        ByteValid;
   logic [7:0]  ByteData;
   logic        ByteReady;
   logic        MemWrite;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        CoreReset;
   logic        Done;
   logic        Error;
   logic [7:0]  WordsLoaded;

   int          checks;
   int          errors;
   int          wr_count;
   logic [31:0] wr_addr [0:63];
   logic [31:0] wr_data [0:63];
   logic [7:0]  good_stream [0:9];
   int          base;

   instruction_loader #(.BASE_ADDR(32'h0)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .ByteValid(ByteValid),
      .ByteData(ByteData), .ByteReady(ByteReady), .MemWrite(MemWrite),
      .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .CoreReset(CoreReset), .Done(Done), .Error(Error),
      .WordsLoaded(WordsLoaded)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial wr_count = 0;
   always @(negedge Clk) begin
      if (MemWrite === 1'b1 && wr_count < 64) begin
         wr_addr[wr_count] = MemAddress;
         wr_data[wr_count] = MemWriteData;
         wr_count = wr_count + 1;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited = 0;
      ByteValid = 1'b1;
      ByteData  = b;
      while (ByteReady !== 1'b1 && waited < 20) begin
         tick(1);
         waited++;
      end
      if (ByteReady !== 1'b1) begin
         check_output("byte_accept_timeout", {31'd0, ByteReady}, 32'd1);
      end else begin
         tick(1);
      end
      ByteValid = 1'b0;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
   endtask

   task automatic gap(input int n);
      ByteValid = 1'b0;
      for (int i = 0; i < n; i++) begin
         ByteData = 8'($urandom);
         tick(1);
      end
   endtask

   task automatic check_good_writes(input string tag, input int first);
      check_output({tag, "_wr_count"}, 32'(wr_count - first), 32'd2);
      check_output({tag, "_addr0"}, wr_addr[first], 32'h0000_0000);
      check_output({tag, "_data0"}, wr_data[first], 32'h2008_0005);
      check_output({tag, "_addr1"}, wr_addr[first+1], 32'h0000_0004);
      check_output({tag, "_data1"}, wr_data[first+1], 32'h0000_0000);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      good_stream[0] = 8'h02; good_stream[1] = 8'h20; good_stream[2] = 8'h08;
      good_stream[3] = 8'h00; good_stream[4] = 8'h05; good_stream[5] = 8'h00;
      good_stream[6] = 8'h00; good_stream[7] = 8'h00; good_stream[8] = 8'h00;
      good_stream[9] = 8'h2F;
      Reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
      tick(2);
      Reset = 1'b0;

      // Reset values
      check_output("rst_ready", {31'd0, ByteReady}, 32'd0);
      check_output("rst_memwrite", {31'd0, MemWrite}, 32'd0);
      check_output("rst_addr", MemAddress, 32'h0);
      check_output("rst_data", MemWriteData, 32'h0);
      check_output("rst_corereset", {31'd0, CoreReset}, 32'd1);
      check_output("rst_done", {31'd0, Done}, 32'd0);
      check_output("rst_error", {31'd0, Error}, 32'd0);
      check_output("rst_words", {24'd0, WordsLoaded}, 32'd0);

      // Session 1: good stream; a byte offered alongside Start must not be taken
      base = wr_count;
      ByteValid = 1'b1; ByteData = 8'hFF;
      pulse_start();
      ByteValid = 1'b0;
      check_output("s1_ready_after_start", {31'd0, ByteReady}, 32'd1);
      check_output("s1_corereset_count", {31'd0, CoreReset}, 32'd1);
      for (int i = 0; i < 10; i++) send_byte(good_stream[i]);
      check_output("s1_done", {31'd0, Done}, 32'd1);
      check_output("s1_error", {31'd0, Error}, 32'd0);
      check_output("s1_corereset", {31'd0, CoreReset}, 32'd0);
      check_output("s1_words", {24'd0, WordsLoaded}, 32'd2);
      check_output("s1_addr_final", MemAddress, 32'h8);
      check_good_writes("s1", base);

      // Session 2: restart from DONE, bad checksum
      pulse_start();
      check_output("s2_restart_corereset", {31'd0, CoreReset}, 32'd1);
      check_output("s2_restart_done", {31'd0, Done}, 32'd0);
      check_output("s2_restart_words", {24'd0, WordsLoaded}, 32'd0);
      check_output("s2_restart_addr", MemAddress, 32'h0);
      base = wr_count;
      for (int i = 0; i < 9; i++) send_byte(good_stream[i]);
      send_byte(8'h30);
      check_output("s2_error", {31'd0, Error}, 32'd1);
      check_output("s2_done", {31'd0, Done}, 32'd0);
      check_output("s2_corereset", {31'd0, CoreReset}, 32'd1);
      check_good_writes("s2", base);

      // Session 3: empty load from ERR
      pulse_start();
      check_output("s3_error_cleared", {31'd0, Error}, 32'd0);
      base = wr_count;
      send_byte(8'h00);
      send_byte(8'h00);
      tick(1);
      check_output("s3_no_write", 32'(wr_count - base), 32'd0);
      check_output("s3_done", {31'd0, Done}, 32'd1);
      check_output("s3_words", {24'd0, WordsLoaded}, 32'd0);
      check_output("s3_addr", MemAddress, 32'h0);

      // Session 4: random gaps, plus Start pulsed mid-DATA which must be ignored
      pulse_start();
      base = wr_count;
      for (int i = 0; i < 10; i++) begin
         send_byte(good_stream[i]);
         if (i == 3) begin
            Start = 1'b1;
            tick(1);
            Start = 1'b0;
         end
         gap($urandom_range(0, 3));
      end
      check_output("s4_done", {31'd0, Done}, 32'd1);
      check_output("s4_words", {24'd0, WordsLoaded}, 32'd2);
      check_good_writes("s4", base);

      // Session 5: reset after 6 payload bytes, with Start and a byte in the same cycle
      pulse_start();
      base = wr_count;
      for (int i = 0; i < 7; i++) send_byte(good_stream[i]);
      check_output("s5_first_word_written", 32'(wr_count - base), 32'd1);
      Reset = 1'b1; Start = 1'b1; ByteValid = 1'b1; ByteData = 8'h00;
      tick(1);
      Reset = 1'b0; Start = 1'b0;
      check_output("s5_rst_ready", {31'd0, ByteReady}, 32'd0);
      check_output("s5_rst_memwrite", {31'd0, MemWrite}, 32'd0);
      check_output("s5_rst_addr", MemAddress, 32'h0);
      check_output("s5_rst_data", MemWriteData, 32'h0);
      check_output("s5_rst_corereset", {31'd0, CoreReset}, 32'd1);
      check_output("s5_rst_words", {24'd0, WordsLoaded}, 32'd0);
      tick(4);
      ByteValid = 1'b0;
      check_output("s5_no_write_after_reset", 32'(wr_count - base), 32'd1);

      // New session after reset writes from BASE_ADDR
      pulse_start();
      base = wr_count;
      send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
      send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h23);
      check_output("s6_done", {31'd0, Done}, 32'd1);
      check_output("s6_words", {24'd0, WordsLoaded}, 32'd1);
      check_output("s6_wr_count", 32'(wr_count - base), 32'd1);
      check_output("s6_addr0", wr_addr[base], 32'h0);
      check_output("s6_data0", wr_data[base], 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 32'h0, byte address of first instruction word written.
REQ-002 SHALL have port: Clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: Start  input  1  single-cycle request to begin a load session.
REQ-005 SHALL have port: ByteValid  input  1  host byte present on ByteData.
REQ-006 SHALL have port: ByteData  input  8  host stream byte.
REQ-007 SHALL have port: ByteReady  output  1  loader can accept a byte; transfer occurs when ByteValid and ByteReady are both high.
REQ-008 SHALL have port: MemWrite  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port: MemAddress  output  32  word-aligned byte address for MemWrite.
REQ-010 SHALL have port: MemWriteData  output  32  instruction word for MemWrite.
REQ-011 SHALL have port: CoreReset  output  1  holds the processor in reset while high.
REQ-012 SHALL have port: Done  output  1  load completed with good checksum.
REQ-013 SHALL have port: Error  output  1  load completed with checksum mismatch.
REQ-014 SHALL have port: WordsLoaded  output  8  count of words written this session.

Function
REQ-015 SHALL use the stream format: count byte N (0..255), then N words of 4 bytes each, most significant byte first, then one checksum byte.
REQ-016 SHALL define the checksum as the XOR of the count byte and all payload bytes.
REQ-017 SHALL implement states IDLE, COUNT, DATA, CHECK, DONE, ERR.
REQ-018 SHALL hold ByteReady high only in COUNT, DATA and CHECK.
REQ-019 SHALL move IDLE->COUNT on the cycle after Start; entry SHALL clear the checksum, byte index, WordsLoaded, Done and Error, set MemAddress to BASE_ADDR, and drive CoreReset high.
REQ-020 SHALL, on accepting a byte in COUNT, latch N; it SHALL go to DATA if N>0 and to CHECK if N=0.
REQ-021 SHALL, in DATA, shift each accepted byte into the word assembly register (first byte to bits 31:24).
REQ-022 SHALL, on accepting byte 4 of a word, present the assembled word on MemWriteData and pulse MemWrite for exactly the following cycle, with MemAddress equal to BASE_ADDR + 4*(word index).
REQ-023 SHALL increment MemAddress by 4 (modulo 2^32) and WordsLoaded by 1 in the cycle after each MemWrite pulse.
REQ-024 SHALL keep ByteReady high during a MemWrite pulse, so back-to-back bytes are accepted with no stall.
REQ-025 SHALL go DATA->CHECK after the last byte of word N is accepted.
REQ-026 SHALL, on accepting the checksum byte in CHECK, go to DONE on a match and to ERR on a mismatch.
REQ-027 SHALL, in DONE, drive Done=1 and CoreReset=0.
REQ-028 SHALL, in ERR, drive Error=1 and Done=0, and keep CoreReset=1.
REQ-029 SHALL ignore Start in COUNT, DATA and CHECK; Start in DONE or ERR SHALL restart the session exactly as in REQ-019.
REQ-030 SHALL tolerate idle cycles (ByteValid low) anywhere in the stream, with no change to state or assembled data.
REQ-031 SHALL not accept a byte presented in the same cycle as Start in IDLE.

Reset
REQ-032 SHALL, on Reset high at a clock edge, go to IDLE with: ByteReady=0, MemWrite=0, MemAddress=BASE_ADDR, MemWriteData=0, CoreReset=1, Done=0, Error=0, WordsLoaded=0, and the checksum and byte index cleared.
REQ-033 SHALL honour Reset asserted mid-session: any pending partial word is discarded, no further MemWrite is issued, and already-written words are left untouched.
REQ-034 SHALL give Reset priority over Start and ByteValid in the same cycle.

Verification
REQ-035 SHALL check: Reset, Start, stream 02 20 08 00 05 00 00 00 00 2F -> MemWrite@0x0 data 0x20080005, MemWrite@0x4 data 0x00000000, then Done=1, CoreReset=0, WordsLoaded=2.
REQ-036 SHALL check: same stream with checksum 0x30 -> both writes occur, then Error=1, Done=0, CoreReset=1.
REQ-037 SHALL check: stream 00 00 -> no MemWrite, Done=1, WordsLoaded=0, MemAddress=BASE_ADDR.
REQ-038 SHALL check: the REQ-035 stream with random ByteValid gaps of 0-3 cycles -> identical writes and result; back-to-back bytes cause no drop.
REQ-039 SHALL check: Reset after 6 payload bytes -> MemWrite never asserts again, all outputs at reset values next cycle; a new Start then writes from BASE_ADDR.
REQ-040 SHALL check: Start pulsed during DATA -> ignored; Start in DONE -> CoreReset=1 and Done=0 on the following cycle.
